// File: rtl/omok_win_checker.sv
// ============================================================================
// omok_win_checker: walks the four lines through a newly placed stone and
// reports a sticky five-in-a-row result.            Revision: 1.0
// ============================================================================
`default_nettype none

module omok_win_checker #(
  parameter int N       = 10,
  parameter int WIN_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             start,
  input  logic [7:0]       pos,
  input  logic [N*N-1:0]   board_state,
  input  logic [N*N-1:0]   turn_map,
  output logic             busy,
  output logic             done,
  output logic             win,
  output logic             winner,
  output logic [1:0]       win_dir
);

  localparam int CELLS  = N * N;
  localparam int RC_W   = $clog2(N);
  localparam int IDX_W  = $clog2(CELLS);
  localparam int STEP_W = 4;
  localparam int CNT_W  = 4;
  localparam int SW     = RC_W + STEP_W + 2;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WIN_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_FWD  = 3'd2,
    S_BWD  = 3'd3,
    S_EVAL = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state;
  logic [RC_W-1:0]     row;
  logic [RC_W-1:0]     col;
  logic                colour;
  logic [1:0]          dir;
  logic [CNT_W-1:0]    count;
  logic [STEP_W-1:0]   step;

  logic                pos_ok;
  logic [IDX_W-1:0]    p_idx;
  logic signed [SW-1:0] d_r, d_c, t_r, t_c;
  logic                in_bounds;
  logic [IDX_W-1:0]    t_idx;
  logic                hit;
  logic [CNT_W-1:0]    count_inc;

  assign pos_ok    = (pos < 8'(CELLS));
  assign p_idx     = IDX_W'(pos);
  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);

  // Probe cell for the current direction; the backward pass mirrors the delta.
  always_comb begin
    d_r = '0;
    d_c = '0;
    case (dir)
      2'd0: d_c = SW'(1);
      2'd1: d_r = SW'(1);
      2'd2: begin d_r = SW'(1); d_c = SW'(1);  end
      default: begin d_r = SW'(1); d_c = SW'(-1); end
    endcase
    if (state == S_BWD) begin
      d_r = -d_r;
      d_c = -d_c;
    end
    t_r       = SW'(row) + d_r * SW'(step);
    t_c       = SW'(col) + d_c * SW'(step);
    in_bounds = !t_r[SW-1] && (t_r < SW'(N)) && !t_c[SW-1] && (t_c < SW'(N));
    t_idx     = IDX_W'($unsigned(t_r)) * IDX_W'(N) + IDX_W'($unsigned(t_c));
    hit       = in_bounds && board_state[t_idx] && (turn_map[t_idx] == colour);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      win     <= 1'b0;
      winner  <= 1'b0;
      win_dir <= 2'd0;
      row     <= '0;
      col     <= '0;
      colour  <= 1'b0;
      dir     <= 2'd0;
      count   <= '0;
      step    <= '0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        win     <= 1'b0;
        winner  <= 1'b0;
        win_dir <= 2'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start && !win) state <= S_LOAD;
          end
          S_LOAD: begin
            row    <= RC_W'(pos / 8'(N));
            col    <= RC_W'(pos % 8'(N));
            colour <= turn_map[p_idx];
            dir    <= 2'd0;
            count  <= CNT_W'(1);
            step   <= STEP_W'(1);
            if (pos_ok && board_state[p_idx]) begin
              state <= S_FWD;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
          S_FWD, S_BWD: begin
            if (hit) count <= count_inc;
            if (hit && step != LAST_STEP) begin
              step <= step + STEP_W'(1);
            end else begin
              step  <= STEP_W'(1);
              state <= (state == S_FWD) ? S_BWD : S_EVAL;
            end
          end
          S_EVAL: begin
            if (count >= CNT_W'(WIN_LEN)) begin
              win     <= 1'b1;
              winner  <= colour;
              win_dir <= dir;
              state   <= S_DONE;
              done    <= 1'b1;
            end else if (dir == 2'd3) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              dir   <= dir + 2'd1;
              count <= CNT_W'(1);
              step  <= STEP_W'(1);
              state <= S_FWD;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

`default_nettype wire
